// File: rtl/dict_loader_pkg.sv
// Shared constants and types for the boot-time dictionary loader.
// The default widths are shared with the instruction-cache controller so
// both sides agree on dictionary geometry.
package dict_loader_pkg;

  // Loader FSM states: fetch a word, write it, then hand imem to the controller.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Default dictionary entry widths.
  localparam int DEF_FIELD1_VAL_WIDTH = 7;
  localparam int DEF_FIELD2_VAL_WIDTH = 10;
  localparam int DEF_FIELD3_VAL_WIDTH = 15;

  // Default dictionary key widths (entry count = 2^key).
  localparam int DEF_FIELD1_KEY_WIDTH = 3;
  localparam int DEF_FIELD2_KEY_WIDTH = 5;
  localparam int DEF_FIELD3_KEY_WIDTH = 8;

  // Byte address of the first dictionary word in instruction memory.
  localparam logic [31:0] DEF_DICT_BASE = 32'h000F_0000;

  // Derived entry counts, per-field word offsets and total word count.
  localparam int FIELD1_ENTRIES = 1 << DEF_FIELD1_KEY_WIDTH;
  localparam int FIELD2_ENTRIES = 1 << DEF_FIELD2_KEY_WIDTH;
  localparam int FIELD3_ENTRIES = 1 << DEF_FIELD3_KEY_WIDTH;
  localparam int FIELD1_BASE    = 0;
  localparam int FIELD2_BASE    = FIELD1_BASE + FIELD1_ENTRIES;
  localparam int FIELD3_BASE    = FIELD2_BASE + FIELD2_ENTRIES;
  localparam int TOTAL_ENTRIES  = FIELD3_BASE + FIELD3_ENTRIES;

  // Largest of three widths; sizes the shared entry index.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/dict_loader.sv
// Boot-time sequencer: reads the three compression dictionaries from imem,
// streams them into the controller's dictionaries one entry per write strobe,
// then passes the imem port through to the controller and releases the core.
//
// Handshake: the loader holds mem_valid/mem_addr steady from the start of a
// request until the cycle mem_ready is high; that cycle transfers mem_rdata.
// After load, mem_valid/mem_addr and ctrl_mem_ready/ctrl_mem_rdata are pure
// combinational pass-through between controller and imem.
module dict_loader
  import dict_loader_pkg::*;
#(
  parameter int          FIELD1_VAL_WIDTH = DEF_FIELD1_VAL_WIDTH,
  parameter int          FIELD2_VAL_WIDTH = DEF_FIELD2_VAL_WIDTH,
  parameter int          FIELD3_VAL_WIDTH = DEF_FIELD3_VAL_WIDTH,
  parameter int          FIELD1_KEY_WIDTH = DEF_FIELD1_KEY_WIDTH,
  parameter int          FIELD2_KEY_WIDTH = DEF_FIELD2_KEY_WIDTH,
  parameter int          FIELD3_KEY_WIDTH = DEF_FIELD3_KEY_WIDTH,
  parameter logic [31:0] DICT_BASE        = DEF_DICT_BASE
) (
  input  logic                        clk,
  input  logic                        reset,
  output logic                        mem_valid,
  output logic [31:0]                 mem_addr,
  input  logic                        mem_ready,
  input  logic [31:0]                 mem_rdata,
  input  logic                        ctrl_mem_valid,
  input  logic [31:0]                 ctrl_mem_addr,
  output logic                        ctrl_mem_ready,
  output logic [31:0]                 ctrl_mem_rdata,
  output logic                        dict1_write_enable,
  output logic [FIELD1_VAL_WIDTH-1:0] dict1_write_val,
  output logic                        dict2_write_enable,
  output logic [FIELD2_VAL_WIDTH-1:0] dict2_write_val,
  output logic                        dict3_write_enable,
  output logic [FIELD3_VAL_WIDTH-1:0] dict3_write_val,
  output logic                        core_resetn,
  output logic                        load_done
);

  localparam int IDX_W = max3(FIELD1_KEY_WIDTH, FIELD2_KEY_WIDTH, FIELD3_KEY_WIDTH);

  localparam logic [IDX_W-1:0] LAST1 = IDX_W'((1 << FIELD1_KEY_WIDTH) - 1);
  localparam logic [IDX_W-1:0] LAST2 = IDX_W'((1 << FIELD2_KEY_WIDTH) - 1);
  localparam logic [IDX_W-1:0] LAST3 = IDX_W'((1 << FIELD3_KEY_WIDTH) - 1);

  // Word offsets of dict2 and dict3 within the dictionary image.
  localparam logic [31:0] BASE2 = 32'(1 << FIELD1_KEY_WIDTH);
  localparam logic [31:0] BASE3 = 32'((1 << FIELD1_KEY_WIDTH) + (1 << FIELD2_KEY_WIDTH));

  localparam logic [1:0] F1 = 2'd1;
  localparam logic [1:0] F2 = 2'd2;
  localparam logic [1:0] F3 = 2'd3;

  state_t                      state, state_d;
  logic [1:0]                  field, field_d;
  logic [IDX_W-1:0]            idx, idx_d;
  logic [IDX_W-1:0]            last_idx;
  logic [31:0]                 g;
  logic [31:0]                 load_addr;
  logic                        done_q;
  logic [FIELD1_VAL_WIDTH-1:0] wval1;
  logic [FIELD2_VAL_WIDTH-1:0] wval2;
  logic [FIELD3_VAL_WIDTH-1:0] wval3;

  // Global word index and last index of the field currently being loaded.
  always_comb begin
    last_idx = LAST1;
    g        = 32'(idx);
    case (field)
      F2: begin
        last_idx = LAST2;
        g        = BASE2 + 32'(idx);
      end
      F3: begin
        last_idx = LAST3;
        g        = BASE3 + 32'(idx);
      end
      default: begin
        last_idx = LAST1;
        g        = 32'(idx);
      end
    endcase
  end

  assign load_addr = DICT_BASE + (g << 2);

  // Next-state logic: one fetch then one write per entry, field by field.
  always_comb begin
    state_d = state;
    field_d = field;
    idx_d   = idx;
    case (state)
      FETCH: begin
        if (mem_ready) state_d = WRITE;
      end
      WRITE: begin
        if (idx != last_idx) begin
          idx_d   = idx + IDX_W'(1);
          state_d = FETCH;
        end else if (field != F3) begin
          field_d = field + 2'd1;
          idx_d   = '0;
          state_d = FETCH;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = FETCH;
        field_d = F1;
        idx_d   = '0;
      end
    endcase
  end

  // State, field and entry index registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH;
      field <= F1;
      idx   <= '0;
    end else begin
      state <= state_d;
      field <= field_d;
      idx   <= idx_d;
    end
  end

  // Capture the truncated imem word into the current field's write register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wval1 <= '0;
      wval2 <= '0;
      wval3 <= '0;
    end else if (state == FETCH && mem_ready) begin
      case (field)
        F2:      wval2 <= mem_rdata[FIELD2_VAL_WIDTH-1:0];
        F3:      wval3 <= mem_rdata[FIELD3_VAL_WIDTH-1:0];
        default: wval1 <= mem_rdata[FIELD1_VAL_WIDTH-1:0];
      endcase
    end
  end

  // Registered completion flag; drives core release and the port hand-over.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) done_q <= 1'b0;
    else       done_q <= (state_d == DONE);
  end

  assign dict1_write_enable = (state == WRITE) && (field == F1);
  assign dict2_write_enable = (state == WRITE) && (field == F2);
  assign dict3_write_enable = (state == WRITE) && (field == F3);
  assign dict1_write_val    = wval1;
  assign dict2_write_val    = wval2;
  assign dict3_write_val    = wval3;

  assign load_done   = done_q;
  assign core_resetn = done_q;

  // imem port mux: loader owns the port until done, then the controller does.
  assign mem_valid      = done_q ? ctrl_mem_valid : (state == FETCH);
  assign mem_addr       = done_q ? ctrl_mem_addr  : load_addr;
  assign ctrl_mem_ready = done_q & mem_ready;
  assign ctrl_mem_rdata = done_q ? mem_rdata : 32'h0;

endmodule

// File: doc/dict_loader.md
# dict_loader

Boot-time sequencer that fills the three compression dictionaries of the instruction-cache `controller` from instruction memory, then hands the `imem` port over to the controller and releases the processor from reset. It sits between `controller`, `imem` and `picorv32`. It replaces bench-driven dictionary preloading with a hardware fetch/write state machine and a two-way `imem` port mux.

## Interface
Parameters:
- `FIELD1_VAL_WIDTH`, 7: dict1 entry width.
- `FIELD2_VAL_WIDTH`, 10: dict2 entry width.
- `FIELD3_VAL_WIDTH`, 15: dict3 entry width.
- `FIELD1_KEY_WIDTH`, 3: dict1 holds 2^3 = 8 entries.
- `FIELD2_KEY_WIDTH`, 5: dict2 holds 32 entries.
- `FIELD3_KEY_WIDTH`, 8: dict3 holds 256 entries.
- `DICT_BASE`, 32'h000F_0000: byte address of the first dictionary word (word-aligned).

Ports:
- `clk`  in  1: the single clock. Everything is synchronous to its rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `mem_valid`  out  1: request to `imem`.
- `mem_addr`  out  32: `imem` address.
- `mem_ready`  in  1: `imem` response strobe.
- `mem_rdata`  in  32: `imem` data, valid while `mem_ready` is high.
- `ctrl_mem_valid`  in  1: request from the controller's `mem_req_valid`.
- `ctrl_mem_addr`  in  32: controller `mem_req_addr`.
- `ctrl_mem_ready`  out  1: returned to the controller.
- `ctrl_mem_rdata`  out  32: returned to the controller.
- `dict1_write_enable`  out  1: one-cycle write strobe for dict1.
- `dict1_write_val`  out  FIELD1_VAL_WIDTH: dict1 write data.
- `dict2_write_enable`  out  1: one-cycle write strobe for dict2.
- `dict2_write_val`  out  FIELD2_VAL_WIDTH: dict2 write data.
- `dict3_write_enable`  out  1: one-cycle write strobe for dict3.
- `dict3_write_val`  out  FIELD3_VAL_WIDTH: dict3 write data.
- `core_resetn`  out  1: active-low reset to `picorv32`.
- `load_done`  out  1: high once all dictionaries are written.

## Operation
- States: `FETCH`, `WRITE`, `DONE`. Reset state is `FETCH` with `field = 1` and `idx = 0`.
- Global word index `g`:
  - field 1: `g = idx`
  - field 2: `g = 8 + idx`
  - field 3: `g = 40 + idx`
  - `g` ranges over 0..295.
- `mem_addr = DICT_BASE + (g << 2)`. Each entry sits in the low `FIELDn_VAL_WIDTH` bits of its word; the upper bits are ignored.
- `FETCH`:
  - `mem_valid = 1`.
  - On `mem_ready`, capture the truncated `mem_rdata` into the write register of the current field and go to `WRITE`.
- `WRITE`: pulse `dictN_write_enable` for the current field only, for exactly one cycle, with `dictN_write_val` stable during that cycle. Next state:
  - `idx < 2^KEYn - 1`: `idx++`, go to `FETCH`.
  - Last entry of field 1 or field 2: `field++`, `idx = 0`, go to `FETCH`.
  - Last entry of field 3: go to `DONE`.
- `DONE`: terminal until reset. `load_done = 1`, `core_resetn = 1`.
- Dictionary entries are written strictly in order 0..2^KEYn-1. The controller's dictionaries use implicit sequential write pointers.
- Port mux:
  - Before `DONE`: the loader owns `imem`. `ctrl_mem_ready = 0` and controller requests are stalled, not dropped.
  - In `DONE`: `mem_valid = ctrl_mem_valid`, `mem_addr = ctrl_mem_addr`, `ctrl_mem_ready = mem_ready`, `ctrl_mem_rdata = mem_rdata`, all combinational pass-through.
- `ctrl_mem_rdata` is 0 before `DONE`.

## Timing
- Reset values:
  - `mem_valid = 1` (state `FETCH`, `g = 0`).
  - `mem_addr = DICT_BASE`.
  - All write enables 0, all write values 0.
  - `core_resetn = 0`, `load_done = 0`, `ctrl_mem_ready = 0`.
- With a zero-wait `imem` (`mem_ready` in the same cycle as `mem_valid`), each entry takes 2 cycles. A full load is 296 × 2 = 592 cycles from reset deassertion to `load_done`.
- Each `imem` wait cycle adds 1 cycle per entry.
- `mem_valid` and `mem_addr` are held constant from request until the `mem_ready` cycle. `mem_valid` is low in `WRITE`.
- `core_resetn` and `load_done` rise in the same cycle, on the first cycle after the final dict3 write strobe, and are registered.
- Reset asserted mid-load:
  - All state clears immediately (asynchronously), including the write enables.
  - The load restarts from `g = 0`.
  - Any partially written dictionary is overwritten. The controller's write pointers are reset by the same reset.
- Only one `dictN_write_enable` is high in any cycle.

## Structure
- Package `dict_loader_pkg` holds:
  - the state enum (`FETCH`, `WRITE`, `DONE`);
  - the default FIELD/KEY width constants, shared with `controller`;
  - the derived entry counts and field base offsets (0, 8, 40) and the total of 296.
- Single flat module, no sub-modules. The port mux is a few assigns inside `dict_loader`.

## Test plan
- Zero-wait `imem` with `DICT_BASE` words set to `g` → dict1 gets 0..7, dict2 gets 8..39, dict3 gets 40..295; `load_done` rises at cycle 592.
- `imem` with 3 wait states → `mem_addr` stable during each wait; load completes at cycle 296 × 5 = 1480; contents unchanged.
- Words with upper bits set (32'hFFFF_FF05 at `g = 0`) → `dict1_write_val = 7'h05`; no other enable pulses in that cycle.
- `reset` pulsed at cycle 100 → enables drop immediately; the next request uses `mem_addr = DICT_BASE`; full reload completes 592 cycles later.
- `ctrl_mem_valid` held high during load → `ctrl_mem_ready = 0` throughout; in the first `DONE` cycle the request passes through and `ctrl_mem_rdata` matches `imem`.
- After `DONE`, drive 10 controller reads to arbitrary addresses → `mem_addr` mirrors `ctrl_mem_addr`; no further dict writes occur.
